// File: rtl/pipeline_pkg.sv
// Purpose: shared FSM encoding and default stage indices for the pipeline sequencer.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package pipeline_pkg;

    // Raw state codes, kept as plain constants so older tooling can match on them.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_TRAP   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        PS_RUN    = ST_RUN,
        PS_TRAP   = ST_TRAP,
        PS_DRAIN  = ST_DRAIN,
        PS_HALTED = ST_HALTED
    } pipe_seq_state_e;

    // Default five-stage layout.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_perf_counter.sv
// Purpose: 32-bit event counter with enable and synchronous clear.
// Latency: an enabled cycle is reflected in count on the following clock.
// Backpressure: none; every enabled cycle counts, wrapping at 2^32.
module pipe_perf_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    output logic [31:0] count
);

    // Clear beats enable; overflow wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Purpose: per-stage stall/flush steering plus trap entry, debug drain/halt and stall watchdog.
// Latency: steering is combinational; irq_ack one cycle after a qualifying irq_req; halt after NUM_STAGES-1 unstalled drain cycles.
// Backpressure: stall_req of a stage holds every register feeding it and below; PIPE_SEQ_PERF_EN adds the perf counters.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int NUM_STAGES    = 5,
    parameter int MEM_STAGE     = STG_MEM,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic                          flush_req,
    input  logic [$clog2(NUM_STAGES)-1:0] flush_upto,
    input  logic                          irq_req,
    input  logic                          halt_req,
    input  logic                          resume_req,
    output logic [NUM_STAGES-2:0]         reg_en,
    output logic [NUM_STAGES-2:0]         reg_clr,
    output logic                          pc_en,
    output logic                          irq_ack,
    output logic                          halted,
    output logic                          stall_timeout,
    output logic [31:0]                   perf_stall_cycles,
    output logic [31:0]                   perf_flush_count
);

    localparam int NREG = NUM_STAGES - 1;
    localparam int FU_W = $clog2(NUM_STAGES);
    localparam int DC_W = $clog2(NUM_STAGES);
    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

    pipe_seq_state_e state_q;
    logic [DC_W-1:0] drain_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic [NREG-1:0] hold;
    logic [NREG-1:0] flush_mask;
    logic [FU_W-1:0] flush_lim;
    logic            any_stall;
    logic            downstream_stall;
    logic            wd_active;

    assign any_stall        = |stall_req;
    assign downstream_stall = |stall_req[NUM_STAGES-1:1];

    // Out-of-range flush limits clear every pipeline register.
    assign flush_lim = (int'(flush_upto) >= NUM_STAGES) ? FU_W'(NUM_STAGES - 1) : flush_upto;

    // Register k must hold whenever any stage beyond it is stalled; build the flush mask alongside.
    always_comb begin
        hold       = '0;
        flush_mask = '0;
        for (int k = 0; k < NREG; k++) begin
            hold[k]       = |(stall_req >> (k + 1));
            flush_mask[k] = (k < int'(flush_lim));
        end
    end

    // Output steering per FSM state; RUN equations are the baseline for every state.
    always_comb begin
        reg_en  = ~hold;
        reg_clr = stall_req[NREG-1:0] & ~hold;
        pc_en   = ~any_stall;
        irq_ack = 1'b0;
        halted  = 1'b0;
        case (state_q)
            PS_RUN: begin
                if (flush_req) begin
                    reg_clr = reg_clr | flush_mask;
                    pc_en   = 1'b1;
                end
            end
            PS_TRAP: begin
                reg_en  = '1;
                reg_clr = '1;
                pc_en   = 1'b1;
                irq_ack = 1'b1;
            end
            PS_DRAIN: begin
                // Fetch is frozen and bubbles are pushed in at the front.
                reg_clr[0] = 1'b1;
                pc_en      = 1'b0;
                if (flush_req) begin
                    reg_clr = reg_clr | flush_mask;
                end
            end
            PS_HALTED: begin
                reg_en  = '0;
                reg_clr = '0;
                pc_en   = 1'b0;
                halted  = 1'b1;
            end
            default: begin
                reg_en = ~hold;
            end
        endcase
    end

    // FSM and drain counter; interrupt wins over halt, and only RUN takes either.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= PS_RUN;
            drain_cnt <= '0;
        end else begin
            case (state_q)
                PS_RUN: begin
                    if (irq_req && !stall_req[MEM_STAGE]) begin
                        state_q <= PS_TRAP;
                    end else if (halt_req && !irq_req) begin
                        state_q   <= PS_DRAIN;
                        drain_cnt <= DC_W'(NUM_STAGES - 1);
                    end
                end
                PS_TRAP: begin
                    state_q <= PS_RUN;
                end
                PS_DRAIN: begin
                    // Only cycles where the bubbles actually move count toward the drain.
                    if (!downstream_stall) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DC_W'(1)) begin
                            state_q <= PS_HALTED;
                        end
                    end
                end
                PS_HALTED: begin
                    if (resume_req) begin
                        state_q <= PS_RUN;
                    end
                end
                default: begin
                    state_q <= PS_RUN;
                end
            endcase
        end
    end

    assign wd_active     = ((state_q == PS_RUN) || (state_q == PS_DRAIN)) && any_stall;
    // Pulse on the stalled cycle that carries the count up to the limit; saturation blocks repeats.
    assign stall_timeout = wd_active && (wd_cnt == WD_W'(STALL_TIMEOUT - 1));

    // Watchdog: counts consecutive stalled cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (wd_active) begin
            if (wd_cnt != WD_W'(STALL_TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end else if (!any_stall) begin
            wd_cnt <= '0;
        end
    end

`ifdef PIPE_SEQ_PERF_EN
    logic stall_cnt_en;
    logic flush_cnt_en;

    assign stall_cnt_en = !pc_en && (state_q != PS_HALTED);
    assign flush_cnt_en = (flush_req && ((state_q == PS_RUN) || (state_q == PS_DRAIN)))
                        || (state_q == PS_TRAP);

    pipe_perf_counter u_perf_stall (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (stall_cnt_en),
        .clr     (1'b0),
        .count   (perf_stall_cycles)
    );

    pipe_perf_counter u_perf_flush (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (flush_cnt_en),
        .clr     (1'b0),
        .count   (perf_flush_count)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Purpose: self-checking bench for pipeline_sequencer (directed plan steps, then random traffic).
// Latency: outputs sampled 2-3 time units after each rising edge.
// Backpressure: n/a.
module tb_pipeline_sequencer;

    localparam int NS  = 5;
    localparam int NR  = NS - 1;
    localparam int MEM = 3;
    localparam int TO  = 8;

    localparam int M_RUN    = 0;
    localparam int M_TRAP   = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic          clk;
    logic          reset_n;
    logic [NS-1:0] stall_req;
    logic          flush_req;
    logic [2:0]    flush_upto;
    logic          irq_req;
    logic          halt_req;
    logic          resume_req;
    logic [NR-1:0] reg_en;
    logic [NR-1:0] reg_clr;
    logic          pc_en;
    logic          irq_ack;
    logic          halted;
    logic          stall_timeout;
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_flush_count;

    pipeline_sequencer #(
        .NUM_STAGES    (NS),
        .MEM_STAGE     (MEM),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .stall_req         (stall_req),
        .flush_req         (flush_req),
        .flush_upto        (flush_upto),
        .irq_req           (irq_req),
        .halt_req          (halt_req),
        .resume_req        (resume_req),
        .reg_en            (reg_en),
        .reg_clr           (reg_clr),
        .pc_en             (pc_en),
        .irq_ack           (irq_ack),
        .halted            (halted),
        .stall_timeout     (stall_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    int          m_mode;
    int          m_drain_left;
    int          m_stall_run;
    logic [31:0] m_pstall;
    logic [31:0] m_pflush;
    int          m_top;

    // Expected outputs
    logic [NR-1:0] e_en;
    logic [NR-1:0] e_clr;
    logic          e_pc;
    logic          e_ack;
    logic          e_halted;
    logic          e_to;

    int wd_pulses;
    int wd_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_mode       = M_RUN;
        m_drain_left = 0;
        m_stall_run  = 0;
        m_pstall     = '0;
        m_pflush     = '0;
    endtask

    // Expected outputs from the current mode and inputs.
    task automatic predict();
        int lim;
        m_top = -1;
        for (int j = 0; j < NS; j++) if (stall_req[j]) m_top = j;
        e_en = '0; e_clr = '0; e_pc = 1'b0; e_ack = 1'b0; e_halted = 1'b0; e_to = 1'b0;
        if (m_mode == M_RUN || m_mode == M_DRAIN) begin
            // A register moves only if nothing beyond it is stuck; a bubble lands right behind the topmost stall.
            for (int k = 0; k < NR; k++) begin
                e_en[k]  = (k >= m_top);
                e_clr[k] = (k == m_top);
            end
            e_pc = (m_top < 0) && (m_mode == M_RUN);
            if (m_mode == M_DRAIN) e_clr[0] = 1'b1;
            if (flush_req) begin
                lim = (int'(flush_upto) > NS - 1) ? NS - 1 : int'(flush_upto);
                for (int k = 0; k < lim; k++) e_clr[k] = 1'b1;
                if (m_mode == M_RUN) e_pc = 1'b1;
            end
            e_to = (m_top >= 0) && (m_stall_run == TO - 1);
        end else if (m_mode == M_TRAP) begin
            e_en = '1; e_clr = '1; e_pc = 1'b1; e_ack = 1'b1;
        end else begin
            e_halted = 1'b1;
        end
    endtask

    // Advance the model across one clock edge with the current inputs.
    task automatic advance();
        if (!reset_n) begin
            reset_model();
        end else begin
`ifdef PIPE_SEQ_PERF_EN
            if (!e_pc && m_mode != M_HALTED) m_pstall = m_pstall + 32'd1;
            if (m_mode == M_TRAP || ((m_mode == M_RUN || m_mode == M_DRAIN) && flush_req))
                m_pflush = m_pflush + 32'd1;
`endif
            if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_top >= 0)
                m_stall_run = (m_stall_run < TO) ? m_stall_run + 1 : TO;
            else if (m_top < 0)
                m_stall_run = 0;
            case (m_mode)
                M_RUN: begin
                    if (irq_req && !stall_req[MEM]) m_mode = M_TRAP;
                    else if (halt_req && !irq_req) begin
                        m_mode = M_DRAIN;
                        m_drain_left = NS - 1;
                    end
                end
                M_TRAP: m_mode = M_RUN;
                M_DRAIN: begin
                    if (m_top <= 0) begin
                        m_drain_left--;
                        if (m_drain_left == 0) m_mode = M_HALTED;
                    end
                end
                default: if (resume_req) m_mode = M_RUN;
            endcase
        end
    endtask

    // Check all outputs against the model, then clock once.
    task automatic step(input string tag);
        #1;
        predict();
        chk({tag, ".reg_en"},  32'(reg_en),  32'(e_en));
        chk({tag, ".reg_clr"}, 32'(reg_clr), 32'(e_clr));
        chk({tag, ".pc_en"},   32'(pc_en),   32'(e_pc));
        chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
        chk({tag, ".halted"},  32'(halted),  32'(e_halted));
        chk({tag, ".timeout"}, 32'(stall_timeout), 32'(e_to));
        chk({tag, ".perf_stall"}, perf_stall_cycles, m_pstall);
        chk({tag, ".perf_flush"}, perf_flush_count,  m_pflush);
        advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; reset_n = 1'b0;
        stall_req = '0; flush_req = 1'b0; flush_upto = '0;
        irq_req = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
        @(posedge clk);
        #1;
        reset_model();

        // Reset state
        #1;
        chk("rst_en", 32'(reg_en), 32'hF);
        chk("rst_clr", 32'(reg_clr), 32'h0);
        chk("rst_pc", 32'(pc_en), 32'h1);
        chk("rst_halted", 32'(halted), 32'h0);
        step("rst");
        reset_n = 1'b1;
        step("idle");

        // Load-use stall
        stall_req = 5'b00010;
        #1;
        chk("lu_en", 32'(reg_en), 32'hE);
        chk("lu_clr", 32'(reg_clr), 32'h2);
        chk("lu_pc", 32'(pc_en), 32'h0);
        step("loaduse");

        // Flush over stall, then saturated flush limit
        flush_req = 1'b1; flush_upto = 3'd3;
        #1;
        chk("fl_clr", 32'(reg_clr), 32'h7);
        chk("fl_pc", 32'(pc_en), 32'h1);
        step("flush");
        stall_req = '0; flush_upto = 3'd7;
        #1;
        chk("flsat_clr", 32'(reg_clr), 32'hF);
        step("flush_sat");
        flush_req = 1'b0; flush_upto = '0;

        // Deferred interrupt behind a memory-stage stall
        irq_req = 1'b1; stall_req = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("irq_wait_ack", 32'(irq_ack), 32'h0);
            step("irq_wait");
        end
        stall_req = '0;
        step("irq_release");
        irq_req = 1'b0;
        #1;
        chk("irq_ack", 32'(irq_ack), 32'h1);
        chk("irq_clr", 32'(reg_clr), 32'hF);
        step("trap");
        step("post_trap");

        // Halt drain with a two-cycle stall of stage 2; irq ignored while draining/halted
        halt_req = 1'b1;
        step("halt_req");
        halt_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stall_req = (i == 1 || i == 2) ? 5'b00100 : 5'b00000;
            irq_req   = (i == 4);
            #1;
            chk("drain_halted", 32'(halted), 32'h0);
            chk("drain_pc", 32'(pc_en), 32'h0);
            step("drain");
        end
        stall_req = '0; irq_req = 1'b1; resume_req = 1'b1;
        #1;
        chk("halted_rise", 32'(halted), 32'h1);
        chk("halted_ack", 32'(irq_ack), 32'h0);
        step("halted");
        resume_req = 1'b0;
        #1;
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_pc", 32'(pc_en), 32'h1);
        step("resume");
        irq_req = 1'b0;
        step("irq_after_resume");
        step("settle");

        // Watchdog: exactly one pulse on the 8th stalled cycle
        wd_pulses = 0; wd_pos = 0;
        stall_req = 5'b10000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall_timeout) begin
                wd_pulses++;
                wd_pos = i + 1;
            end
            step("wd");
        end
        chk("wd_pulses", 32'(wd_pulses), 32'd1);
        chk("wd_pos", 32'(wd_pos), 32'd8);
        stall_req = '0;
        step("wd_clear");

        // Reset in the middle of a drain
        halt_req = 1'b1;
        step("halt2");
        halt_req = 1'b0;
        step("drain2");
        reset_n = 1'b0;
        step("drain_rst");
        reset_n = 1'b1;
        #1;
        chk("rstdrain_halted", 32'(halted), 32'h0);
        chk("rstdrain_pc", 32'(pc_en), 32'h1);
        chk("rstdrain_pstall", perf_stall_cycles, 32'h0);
        chk("rstdrain_pflush", perf_flush_count, 32'h0);
        step("after_rst");

        // Reset in the middle of a trap: no ack afterwards
        irq_req = 1'b1;
        step("irq2");
        irq_req = 1'b0; reset_n = 1'b0;
        step("trap_rst");
        reset_n = 1'b1;
        #1;
        chk("rsttrap_ack", 32'(irq_ack), 32'h0);
        step("after_rst2");

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int j = 0; j < NS; j++)
                stall_req[j] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) stall_req = '0;
            flush_req  = ($urandom_range(0, 4) == 0);
            flush_upto = 3'($urandom_range(0, 7));
            irq_req    = ($urandom_range(0, 9) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            resume_req = ($urandom_range(0, 4) == 0);
            reset_n    = ($urandom_range(0, 99) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
